// File: rtl/rpn_sequencer.sv
// rpn_sequencer: issue stage in front of stack_alu.
// Consumes a postfix token stream, issues one ALU opcode per instruction,
// tracks the ALU stack depth to catch underflow/overflow before issue,
// and reports one result or error code per expression.
module rpn_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [1:0]   tok_kind,
    input  logic [N-1:0] tok_data,
    output logic [2:0]   alu_opcode,
    output logic [N-1:0] alu_data,
    input  logic [N-1:0] alu_output,
    input  logic         alu_overflow,
    output logic         res_valid,
    output logic [N-1:0] res_data,
    output logic [1:0]   res_error,
    output logic         busy
);

    localparam int unsigned DW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_UNDER = 2'b10;
    localparam logic [1:0] ERR_FULL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FLUSH,
        S_CLEAN,
        S_REPORT
    } state_t;

    typedef enum logic [1:0] {
        K_OPND = 2'b00,
        K_ADD  = 2'b01,
        K_MUL  = 2'b10,
        K_END  = 2'b11
    } kind_t;

    state_t         state_q;
    kind_t          pend_q;      // kind of the token currently being issued
    logic [DW-1:0]  depth_q;     // entries held in the ALU stack
    logic [1:0]     err_q;       // first error seen in this expression
    logic [2:0]     opcode_q;
    logic [N-1:0]   alu_data_q;
    logic           res_valid_q;
    logic [N-1:0]   res_data_q;
    logic [1:0]     res_error_q;

    kind_t tok_kind_e;
    assign tok_kind_e = kind_t'(tok_kind);

    // Ready and busy are pure decodes of the state register; ready is held low while in reset.
    assign tok_ready  = rst_n && ((state_q == S_IDLE) || (state_q == S_FLUSH));
    assign busy       = (state_q != S_IDLE);
    assign alu_opcode = opcode_q;
    assign alu_data   = alu_data_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_error  = res_error_q;

    // Sequencer FSM with registered ALU and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= K_OPND;
            depth_q     <= '0;
            err_q       <= ERR_OK;
            opcode_q    <= OP_NOP;
            alu_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_error_q <= ERR_OK;
        end else begin
            // Opcodes and the result strobe are single-cycle pulses.
            opcode_q    <= OP_NOP;
            res_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (tok_valid) begin
                        case (tok_kind_e)
                            K_OPND: begin
                                if (depth_q == DW'(DEPTH)) begin
                                    err_q   <= ERR_FULL;
                                    state_q <= S_FLUSH;
                                end else begin
                                    opcode_q   <= OP_PUSH;
                                    alu_data_q <= tok_data;
                                    depth_q    <= depth_q + 1'b1;
                                    pend_q     <= K_OPND;
                                    state_q    <= S_ISSUE;
                                end
                            end
                            K_ADD, K_MUL: begin
                                if (depth_q < DW'(2)) begin
                                    err_q   <= ERR_UNDER;
                                    state_q <= S_FLUSH;
                                end else begin
                                    opcode_q <= (tok_kind_e == K_ADD) ? OP_ADD : OP_MUL;
                                    pend_q   <= tok_kind_e;
                                    state_q  <= S_ISSUE;
                                end
                            end
                            default: begin
                                if (depth_q == DW'(1)) begin
                                    opcode_q <= OP_POP;
                                    pend_q   <= K_END;
                                    state_q  <= S_ISSUE;
                                end else begin
                                    err_q   <= (depth_q == '0) ? ERR_UNDER : ERR_FULL;
                                    state_q <= S_CLEAN;
                                end
                            end
                        endcase
                    end
                end

                S_ISSUE: begin
                    alu_data_q <= '0;
                    state_q    <= (pend_q == K_OPND) ? S_IDLE : S_WAIT;
                end

                S_WAIT: begin
                    if (pend_q == K_END) begin
                        depth_q     <= '0;
                        res_data_q  <= alu_output;
                        res_error_q <= err_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_REPORT;
                    end else begin
                        depth_q <= depth_q - 1'b1;
                        if (alu_overflow) begin
                            if (err_q == ERR_OK) begin
                                err_q <= ERR_OVF;
                            end
                            state_q <= S_FLUSH;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_FLUSH: begin
                    if (tok_valid && (tok_kind_e == K_END)) begin
                        state_q <= S_CLEAN;
                    end
                end

                // Drain the ALU one pop per cycle; the last pop overlaps the step into REPORT.
                S_CLEAN: begin
                    if (depth_q != '0) begin
                        opcode_q <= OP_POP;
                        depth_q  <= depth_q - 1'b1;
                    end else begin
                        res_data_q  <= (err_q == ERR_OK) ? res_data_q : '0;
                        res_error_q <= err_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_REPORT;
                    end
                end

                S_REPORT: begin
                    err_q   <= ERR_OK;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Testbench for rpn_sequencer: two instances (DEPTH=512 and DEPTH=4) each
// driving a behavioural stack ALU; expected opcodes and results are queued
// by the stimulus and consumed by a negedge monitor.
module tb_rpn_sequencer;

    localparam logic [1:0] OPD = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] ENDT = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tok_valid [2];
    logic       tok_ready [2];
    logic [1:0] tok_kind  [2];
    logic [7:0] tok_data  [2];
    logic [2:0] opc       [2];
    logic [7:0] dat       [2];
    logic [7:0] alu_out   [2];
    logic       alu_ovf   [2];
    logic       rv        [2];
    logic [7:0] rd        [2];
    logic [1:0] re        [2];
    logic       busy      [2];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct { int inst; logic [2:0] op; } op_t;
    typedef struct { int inst; logic [1:0] err; logic [7:0] data; int at; } res_t;
    op_t  op_q[$];
    res_t res_q[$];

    rpn_sequencer #(.N(8), .DEPTH(512)) u0 (
        .clk(clk), .rst_n(rst_n),
        .tok_valid(tok_valid[0]), .tok_ready(tok_ready[0]),
        .tok_kind(tok_kind[0]), .tok_data(tok_data[0]),
        .alu_opcode(opc[0]), .alu_data(dat[0]),
        .alu_output(alu_out[0]), .alu_overflow(alu_ovf[0]),
        .res_valid(rv[0]), .res_data(rd[0]), .res_error(re[0]), .busy(busy[0])
    );

    rpn_sequencer #(.N(8), .DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .tok_valid(tok_valid[1]), .tok_ready(tok_ready[1]),
        .tok_kind(tok_kind[1]), .tok_data(tok_data[1]),
        .alu_opcode(opc[1]), .alu_data(dat[1]),
        .alu_output(alu_out[1]), .alu_overflow(alu_ovf[1]),
        .res_valid(rv[1]), .res_data(rd[1]), .res_error(re[1]), .busy(busy[1])
    );

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural stack ALU: registered output, signed 8-bit overflow flag.
    logic signed [7:0] stk [2][16];
    int sp [2];

    function automatic int calc(input logic [2:0] op, input logic signed [7:0] a,
                                input logic signed [7:0] b);
        if (op == 3'b100) return int'(a) + int'(b);
        return int'(a) * int'(b);
    endfunction

    function automatic logic ovf(input int r);
        return (r > 127) || (r < -128);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                sp[i]      <= 0;
                alu_out[i] <= '0;
                alu_ovf[i] <= 1'b0;
            end else begin
                alu_ovf[i] <= 1'b0;
                case (opc[i])
                    3'b110: if (sp[i] < 16) begin
                        stk[i][sp[i]] <= dat[i];
                        sp[i]         <= sp[i] + 1;
                        alu_out[i]    <= dat[i];
                    end
                    3'b100, 3'b101: if (sp[i] >= 2) begin
                        stk[i][sp[i]-2] <= 8'(calc(opc[i], stk[i][sp[i]-2], stk[i][sp[i]-1]));
                        alu_out[i]      <= 8'(calc(opc[i], stk[i][sp[i]-2], stk[i][sp[i]-1]));
                        alu_ovf[i]      <= ovf(calc(opc[i], stk[i][sp[i]-2], stk[i][sp[i]-1]));
                        sp[i]           <= sp[i] - 1;
                    end
                    3'b111: if (sp[i] >= 1) begin
                        alu_out[i] <= stk[i][sp[i]-1];
                        sp[i]      <= sp[i] - 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic eop(input int i, input logic [2:0] op);
        op_t e;
        e.inst = i; e.op = op;
        op_q.push_back(e);
    endtask

    task automatic eres(input int i, input logic [1:0] err, input logic [7:0] d, input int at);
        res_t e;
        e.inst = i; e.err = err; e.data = d; e.at = at;
        res_q.push_back(e);
    endtask

    task automatic monitor();
        op_t  eo;
        res_t er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    if (opc[i] != 3'b000) begin
                        check("ready_low_while_issuing", 32'(tok_ready[i]), 32'd0);
                        check("busy_while_issuing", 32'(busy[i]), 32'd1);
                        if (op_q.size() == 0 || op_q[0].inst != i) begin
                            checks++; errors++;
                            $display("FAIL unexpected_opcode inst%0d: got %0b expected none", i, opc[i]);
                        end else begin
                            eo = op_q.pop_front();
                            check($sformatf("opcode_inst%0d", i), 32'(opc[i]), 32'(eo.op));
                        end
                    end
                    if (rv[i]) begin
                        if (res_q.size() == 0 || res_q[0].inst != i) begin
                            checks++; errors++;
                            $display("FAIL unexpected_result inst%0d: got err %0b data %0d expected none", i, re[i], rd[i]);
                        end else begin
                            er = res_q.pop_front();
                            check($sformatf("res_error_inst%0d", i), 32'(re[i]), 32'(er.err));
                            check($sformatf("res_data_inst%0d", i), 32'(rd[i]), 32'(er.data));
                            if (er.at >= 0) check("res_latency", 32'(cycle), 32'(er.at));
                        end
                    end
                end
            end
        end
    endtask

    // Present one token and return the cycle stamp just after it was accepted.
    task automatic send(input int i, input logic [1:0] k, input logic [7:0] d, output int acc);
        bit got = 0;
        tok_valid[i] = 1'b1; tok_kind[i] = k; tok_data[i] = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (tok_ready[i]) begin got = 1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL tok_ready_timeout inst%0d: got 0 expected 1", i);
        end
        @(posedge clk); #1;
        acc = cycle;
        // Junk on kind/data while invalid must be ignored.
        tok_valid[i] = 1'b0; tok_kind[i] = ENDT; tok_data[i] = 8'hA5;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (op_q.size() == 0 && res_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", 32'(op_q.size() + res_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int i);
        check("rst_tok_ready", 32'(tok_ready[i]), 32'd0);
        check("rst_opcode",    32'(opc[i]),       32'd0);
        check("rst_alu_data",  32'(dat[i]),       32'd0);
        check("rst_res_valid", 32'(rv[i]),        32'd0);
        check("rst_res_data",  32'(rd[i]),        32'd0);
        check("rst_res_error", 32'(re[i]),        32'd0);
        check("rst_busy",      32'(busy[i]),      32'd0);
    endtask

    initial begin
        int a;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tok_valid[i] = 1'b0; tok_kind[i] = 2'b00; tok_data[i] = 8'h00;
        end
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3 4 add end -> 7
        eop(0, 3'b110); eop(0, 3'b110); eop(0, 3'b100); eop(0, 3'b111);
        send(0, OPD, 8'd3, a);
        send(0, OPD, 8'd4, a);
        send(0, ADD, 8'd0, a);
        send(0, ENDT, 8'd0, a);
        eres(0, 2'b00, 8'd7, a + 2);
        drain();

        // 5 6 mul -2 add end -> 28
        eop(0, 3'b110); eop(0, 3'b110); eop(0, 3'b101);
        eop(0, 3'b110); eop(0, 3'b100); eop(0, 3'b111);
        send(0, OPD, 8'd5, a);
        send(0, OPD, 8'd6, a);
        send(0, MUL, 8'd0, a);
        send(0, OPD, 8'hFE, a);
        send(0, ADD, 8'd0, a);
        send(0, ENDT, 8'd0, a);
        eres(0, 2'b00, 8'd28, a + 2);
        drain();

        // 100 100 add 1 end -> overflow, one cleanup pop
        eop(0, 3'b110); eop(0, 3'b110); eop(0, 3'b100); eop(0, 3'b111);
        send(0, OPD, 8'd100, a);
        send(0, OPD, 8'd100, a);
        send(0, ADD, 8'd0, a);
        send(0, OPD, 8'd1, a);
        send(0, ENDT, 8'd0, a);
        eres(0, 2'b01, 8'd0, -1);
        drain();

        // 7 add 9 end -> underflow, no add issued, one cleanup pop
        eop(0, 3'b110); eop(0, 3'b111);
        send(0, OPD, 8'd7, a);
        send(0, ADD, 8'd0, a);
        send(0, OPD, 8'd9, a);
        send(0, ENDT, 8'd0, a);
        eres(0, 2'b10, 8'd0, -1);
        drain();

        // 2 3 end -> unbalanced, two pops
        eop(0, 3'b110); eop(0, 3'b110); eop(0, 3'b111); eop(0, 3'b111);
        send(0, OPD, 8'd2, a);
        send(0, OPD, 8'd3, a);
        send(0, ENDT, 8'd0, a);
        eres(0, 2'b11, 8'd0, -1);
        drain();

        // end on empty stack -> underflow, no pops
        send(0, ENDT, 8'd0, a);
        eres(0, 2'b10, 8'd0, -1);
        drain();

        // DEPTH=4: five operands then end -> stack full, four pops
        for (int k = 0; k < 4; k++) eop(1, 3'b110);
        for (int k = 0; k < 4; k++) eop(1, 3'b111);
        for (int k = 0; k < 5; k++) send(1, OPD, 8'(k + 1), a);
        send(1, ENDT, 8'd0, a);
        eres(1, 2'b11, 8'd0, -1);
        drain();

        // 3 4, reset, then 1 1 add end -> 2
        eop(0, 3'b110); eop(0, 3'b110);
        send(0, OPD, 8'd3, a);
        send(0, OPD, 8'd4, a);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset(0);
        rst_n = 1'b1;
        eop(0, 3'b110); eop(0, 3'b110); eop(0, 3'b100); eop(0, 3'b111);
        send(0, OPD, 8'd1, a);
        send(0, OPD, 8'd1, a);
        send(0, ADD, 8'd0, a);
        send(0, ENDT, 8'd0, a);
        eres(0, 2'b00, 8'd2, a + 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
